// File: rtl/my_ram_8_arbiter_if.sv
// Request/response bundle for both requester ports plus the RAM pin group
// driven by my_ram_8_arbiter.
interface my_ram_8_arbiter_if #(
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 3
);
  logic              a_req;
  logic              a_we;
  logic [ADDR_W-1:0] a_addr;
  logic [WIDTH-1:0]  a_wdata;
  logic              a_gnt;
  logic              a_done;
  logic [WIDTH-1:0]  a_rdata;

  logic              b_req;
  logic              b_we;
  logic [ADDR_W-1:0] b_addr;
  logic [WIDTH-1:0]  b_wdata;
  logic              b_gnt;
  logic              b_done;
  logic [WIDTH-1:0]  b_rdata;

  logic [WIDTH-1:0]  ram_out;
  logic [WIDTH-1:0]  ram_in;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_load;

  modport master (
    output a_req, a_we, a_addr, a_wdata,
    input  a_gnt, a_done, a_rdata,
    output b_req, b_we, b_addr, b_wdata,
    input  b_gnt, b_done, b_rdata,
    output ram_out,
    input  ram_in, ram_addr, ram_load
  );

  modport slave (
    input  a_req, a_we, a_addr, a_wdata,
    output a_gnt, a_done, a_rdata,
    input  b_req, b_we, b_addr, b_wdata,
    output b_gnt, b_done, b_rdata,
    input  ram_out,
    output ram_in, ram_addr, ram_load
  );
endinterface

// File: rtl/my_ram_8_arbiter.sv
// Two-port arbiter/sequencer for a shared my_ram_8: one transaction in flight,
// IDLE -> ACCESS -> RESP, round-robin or fixed-priority (A first) selection.
module my_ram_8_arbiter #(
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 3,
  parameter int RR_EN  = 1
) (
  input logic               clk,
  input logic               rst_n,
  my_ram_8_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  typedef enum logic {OWN_A, OWN_B} owner_t;

  state_t            state, state_nxt;
  owner_t            owner, last_owner;
  logic              cmd_we;
  logic [ADDR_W-1:0] cmd_addr;
  logic [WIDTH-1:0]  cmd_wdata;
  logic [WIDTH-1:0]  a_rdata_q, b_rdata_q;
  logic              any_req, pick_b;

  assign any_req = bus.a_req | bus.b_req;
  assign pick_b  = bus.b_req & (~bus.a_req | ((RR_EN != 0) & (last_owner == OWN_A)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      owner      <= OWN_A;
      last_owner <= OWN_B;
      cmd_we     <= 1'b0;
      cmd_addr   <= '0;
      cmd_wdata  <= '0;
      a_rdata_q  <= '0;
      b_rdata_q  <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (any_req) begin
          owner     <= pick_b ? OWN_B : OWN_A;
          cmd_we    <= pick_b ? bus.b_we    : bus.a_we;
          cmd_addr  <= pick_b ? bus.b_addr  : bus.a_addr;
          cmd_wdata <= pick_b ? bus.b_wdata : bus.a_wdata;
        end
        ACCESS: if (!cmd_we) begin
          if (owner == OWN_A) a_rdata_q <= bus.ram_out;
          else                b_rdata_q <= bus.ram_out;
        end
        RESP: last_owner <= owner;
        default: ;
      endcase
    end
  end

  assign bus.a_rdata = a_rdata_q;
  assign bus.b_rdata = b_rdata_q;

  // gnt is combinational in IDLE so the command is accepted on the edge that
  // closes the grant cycle; rst_n gating keeps it low while reset is held.
  always_comb begin
    state_nxt    = state;
    bus.a_gnt    = 1'b0;
    bus.b_gnt    = 1'b0;
    bus.a_done   = 1'b0;
    bus.b_done   = 1'b0;
    bus.ram_load = 1'b0;
    bus.ram_addr = '0;
    bus.ram_in   = '0;
    case (state)
      IDLE: if (any_req) begin
        bus.a_gnt = rst_n & ~pick_b;
        bus.b_gnt = rst_n & pick_b;
        state_nxt = ACCESS;
      end
      ACCESS: begin
        bus.ram_load = cmd_we;
        bus.ram_addr = cmd_addr;
        bus.ram_in   = cmd_wdata;
        state_nxt    = RESP;
      end
      RESP: begin
        bus.a_done = (owner == OWN_A);
        bus.b_done = (owner == OWN_B);
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_my_ram_8_arbiter.sv
// Directed bench: round-robin instance plus a fixed-priority instance, each with
// a behavioural 8x16 RAM beside it.
module tb_my_ram_8_arbiter;

  logic clk;
  logic rst_n;
  int   cyc;
  int   checks;
  int   errors;

  my_ram_8_arbiter_if #(.WIDTH(16), .ADDR_W(3)) rr ();
  my_ram_8_arbiter_if #(.WIDTH(16), .ADDR_W(3)) fp ();

  my_ram_8_arbiter #(.WIDTH(16), .ADDR_W(3), .RR_EN(1)) dut_rr (.clk(clk), .rst_n(rst_n), .bus(rr));
  my_ram_8_arbiter #(.WIDTH(16), .ADDR_W(3), .RR_EN(0)) dut_fp (.clk(clk), .rst_n(rst_n), .bus(fp));

  logic [15:0] mem_rr [8];
  logic [15:0] mem_fp [8];

  assign rr.ram_out = mem_rr[rr.ram_addr];
  assign fp.ram_out = mem_fp[fp.ram_addr];

  always @(posedge clk) begin
    if (rr.ram_load) mem_rr[rr.ram_addr] <= rr.ram_in;
    if (fp.ram_load) mem_fp[fp.ram_addr] <= fp.ram_in;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Drives one transaction on the rr instance and records grant/done cycles.
  task automatic do_xact(input bit port_b, input logic we, input logic [2:0] addr,
                         input logic [15:0] wdata, output int gcyc, output int dcyc,
                         output logic [15:0] rdata);
    gcyc = -1;
    dcyc = -1;
    @(posedge clk); #1;
    if (!port_b) begin
      rr.a_req = 1'b1; rr.a_we = we; rr.a_addr = addr; rr.a_wdata = wdata;
    end else begin
      rr.b_req = 1'b1; rr.b_we = we; rr.b_addr = addr; rr.b_wdata = wdata;
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if ((port_b ? rr.b_gnt : rr.a_gnt) === 1'b1) begin
        gcyc = cyc;
        break;
      end
    end
    @(posedge clk); #1;
    if (!port_b) begin
      rr.a_req = 1'b0; rr.a_we = ~we; rr.a_addr = addr + 3'd1; rr.a_wdata = ~wdata;
    end else begin
      rr.b_req = 1'b0; rr.b_we = ~we; rr.b_addr = addr + 3'd1; rr.b_wdata = ~wdata;
    end
    if (gcyc >= 0) begin
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        if ((port_b ? rr.b_done : rr.a_done) === 1'b1) begin
          dcyc = cyc;
          break;
        end
      end
    end
    rdata = port_b ? rr.b_rdata : rr.a_rdata;
  endtask

  task automatic test_reset();
    logic [15:0] expv;
    @(negedge clk);
    checks++;
    if ({rr.a_gnt, rr.b_gnt, rr.a_done, rr.b_done, rr.ram_load, rr.ram_addr, rr.ram_in,
         rr.a_rdata, rr.b_rdata} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got gnt=%b%b done=%b%b load=%b addr=%0d in=%h ra=%h rb=%h, want all 0",
               rr.a_gnt, rr.b_gnt, rr.a_done, rr.b_done, rr.ram_load, rr.ram_addr, rr.ram_in,
               rr.a_rdata, rr.b_rdata);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    rr.a_req = 1'b1; rr.a_we = 1'b1; rr.a_addr = 3'd3; rr.a_wdata = 16'h1234;
    @(negedge clk);
    checks++;
    if (rr.a_gnt !== 1'b1) begin
      errors++;
      $display("FAIL reset_first_gnt: a_gnt=%b want 1", rr.a_gnt);
    end
    @(posedge clk); #1;
    expv = 16'h1234;
    checks++;
    if (rr.ram_load !== 1'b1 || rr.ram_addr !== 3'd3 || rr.ram_in !== expv) begin
      errors++;
      $display("FAIL access_pins: load=%b addr=%0d in=%h want 1 3 1234", rr.ram_load, rr.ram_addr, rr.ram_in);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({rr.ram_load, rr.a_gnt, rr.b_gnt, rr.a_done, rr.b_done, rr.a_rdata, rr.b_rdata} !== '0) begin
      errors++;
      $display("FAIL reset_mid_access: load=%b gnt=%b%b done=%b%b ra=%h rb=%h want all 0",
               rr.ram_load, rr.a_gnt, rr.b_gnt, rr.a_done, rr.b_done, rr.a_rdata, rr.b_rdata);
    end
    rr.a_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({rr.ram_load, rr.ram_addr, rr.ram_in, rr.a_gnt, rr.b_gnt, rr.a_done, rr.b_done} !== '0) begin
      errors++;
      $display("FAIL post_reset_idle: load=%b addr=%0d in=%h gnt=%b%b done=%b%b want all 0",
               rr.ram_load, rr.ram_addr, rr.ram_in, rr.a_gnt, rr.b_gnt, rr.a_done, rr.b_done);
    end
    rr.a_req = 1'b1; rr.a_we = 1'b0; rr.a_addr = 3'd0;
    @(negedge clk);
    checks++;
    if (rr.a_gnt !== 1'b1) begin
      errors++;
      $display("FAIL post_reset_gnt: a_gnt=%b want 1", rr.a_gnt);
    end
    @(posedge clk); #1;
    rr.a_req = 1'b0;
    repeat (3) @(posedge clk);
  endtask

  task automatic test_write_read();
    int g, d;
    logic [15:0] rd;
    for (int i = 0; i < 8; i++) begin
      do_xact(1'b0, 1'b1, 3'(i), 16'(i + 2), g, d, rd);
      checks++;
      if (g < 0 || d - g !== 2) begin
        errors++;
        $display("FAIL write_latency[%0d]: gnt=%0d done=%0d want done=gnt+2", i, g, d);
      end
    end
    for (int i = 0; i < 8; i++) begin
      do_xact(1'b0, 1'b0, 3'(i), 16'h0000, g, d, rd);
      checks++;
      if (g < 0 || d - g !== 2 || rd !== 16'(i + 2)) begin
        errors++;
        $display("FAIL read[%0d]: gnt=%0d done=%0d rdata=%h want done=gnt+2 rdata=%h", i, g, d, rd, 16'(i + 2));
      end
    end
  endtask

  task automatic test_round_robin();
    int gp[4];
    int gc[4];
    int n;
    n = 0;
    @(negedge clk) rst_n = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    rr.a_req = 1'b1; rr.a_we = 1'b0; rr.a_addr = 3'd1;
    rr.b_req = 1'b1; rr.b_we = 1'b0; rr.b_addr = 3'd2;
    for (int i = 0; i < 30 && n < 4; i++) begin
      @(negedge clk);
      checks++;
      if ((rr.a_gnt & rr.b_gnt) !== 1'b0 || (rr.a_done & rr.b_done) !== 1'b0) begin
        errors++;
        $display("FAIL rr_exclusive: gnt=%b%b done=%b%b", rr.a_gnt, rr.b_gnt, rr.a_done, rr.b_done);
      end
      if (rr.a_gnt === 1'b1 || rr.b_gnt === 1'b1) begin
        gp[n] = rr.b_gnt ? 1 : 0;
        gc[n] = cyc;
        n++;
      end
    end
    @(posedge clk); #1;
    rr.a_req = 1'b0; rr.b_req = 1'b0;
    repeat (4) @(posedge clk);
    checks++;
    if (n !== 4) begin
      errors++;
      $display("FAIL rr_grant_count: got %0d want 4", n);
    end else begin
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (gp[k] !== k % 2 || (k > 0 && gc[k] - gc[k-1] !== 3)) begin
          errors++;
          $display("FAIL rr_grant[%0d]: port=%0d gap=%0d want port=%0d gap=3", k, gp[k],
                   (k > 0) ? gc[k] - gc[k-1] : 3, k % 2);
        end
      end
    end
  endtask

  task automatic test_fixed_priority();
    int na, nb;
    logic seen_b;
    na = 0; nb = 0; seen_b = 1'b0;
    @(posedge clk); #1;
    fp.a_req = 1'b1; fp.a_we = 1'b0; fp.a_addr = 3'd4;
    fp.b_req = 1'b1; fp.b_we = 1'b0; fp.b_addr = 3'd6;
    for (int i = 0; i < 15 && na < 3; i++) begin
      @(negedge clk);
      if (fp.a_gnt === 1'b1) na++;
      if (fp.b_gnt === 1'b1) nb++;
    end
    checks++;
    if (na !== 3 || nb !== 0) begin
      errors++;
      $display("FAIL fp_a_wins: a grants=%0d b grants=%0d want 3 0", na, nb);
    end
    @(posedge clk); #1;
    fp.a_req = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (fp.b_gnt === 1'b1) begin
        seen_b = 1'b1;
        break;
      end
    end
    checks++;
    if (seen_b !== 1'b1) begin
      errors++;
      $display("FAIL fp_b_after_a_drop: b_gnt seen=%b want 1", seen_b);
    end
    @(posedge clk); #1;
    fp.b_req = 1'b0;
    repeat (3) @(posedge clk);
  endtask

  task automatic test_cross_port();
    int g, d;
    logic [15:0] rd, a_before;
    do_xact(1'b0, 1'b0, 3'd2, 16'h0000, g, d, rd);
    checks++;
    if (rd !== 16'h0004) begin
      errors++;
      $display("FAIL a_read_addr2: got %h want 0004", rd);
    end
    a_before = 16'h0004;
    do_xact(1'b0, 1'b1, 3'd5, 16'hBEEF, g, d, rd);
    do_xact(1'b1, 1'b0, 3'd5, 16'h0000, g, d, rd);
    checks++;
    if (g < 0 || d - g !== 2 || rd !== 16'hBEEF) begin
      errors++;
      $display("FAIL b_read_beef: gnt=%0d done=%0d rdata=%h want done=gnt+2 rdata=beef", g, d, rd);
    end
    checks++;
    if (rr.a_rdata !== a_before) begin
      errors++;
      $display("FAIL a_rdata_held: got %h want %h", rr.a_rdata, a_before);
    end
  endtask

  task automatic test_back_to_back();
    int ga, da, gb;
    ga = -1; da = -1; gb = -1;
    @(posedge clk); #1;
    rr.a_req = 1'b1; rr.a_we = 1'b1; rr.a_addr = 3'd7; rr.a_wdata = 16'h7777;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (rr.a_gnt === 1'b1) begin
        ga = cyc;
        break;
      end
    end
    @(posedge clk); #1;
    rr.a_req = 1'b0;
    rr.b_req = 1'b1; rr.b_we = 1'b0; rr.b_addr = 3'd7;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (rr.a_done === 1'b1) da = cyc;
      if (rr.b_gnt === 1'b1) begin
        gb = cyc;
        break;
      end
    end
    @(posedge clk); #1;
    rr.b_req = 1'b0;
    checks++;
    if (ga < 0 || da - ga !== 2 || gb - ga !== 3) begin
      errors++;
      $display("FAIL b_waits: a_gnt=%0d a_done=%0d b_gnt=%0d want a_done=+2 b_gnt=+3", ga, da, gb);
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (rr.b_done === 1'b1) break;
    end
    checks++;
    if (rr.b_rdata !== 16'h7777) begin
      errors++;
      $display("FAIL b_read_7777: got %h want 7777", rr.b_rdata);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    foreach (mem_rr[i]) mem_rr[i] = '0;
    foreach (mem_fp[i]) mem_fp[i] = '0;
    rr.a_req = 1'b0; rr.a_we = 1'b0; rr.a_addr = '0; rr.a_wdata = '0;
    rr.b_req = 1'b0; rr.b_we = 1'b0; rr.b_addr = '0; rr.b_wdata = '0;
    fp.a_req = 1'b0; fp.a_we = 1'b0; fp.a_addr = '0; fp.a_wdata = '0;
    fp.b_req = 1'b0; fp.b_we = 1'b0; fp.b_addr = '0; fp.b_wdata = '0;
    test_reset();
    test_write_read();
    test_round_robin();
    test_fixed_priority();
    test_cross_port();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
